// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request front-end between the pipeline MEM stage and mem_system.
// Accepts one load/store at a time, rejects malformed requests, holds the
// request stable toward mem_system until Done, and stalls the pipeline meanwhile.
// Keeps saturating hit/miss counters and a BUSY-state hang watchdog.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/rd/wr          pipeline request strobe and kind (load/store)
//   req_addr, req_wdata      byte address (must be even), store data
//   pipe_stall               hold the pipeline MEM stage
//   resp_valid, resp_rdata   one-cycle completion pulse, load data (held between responses)
//   ctrl_err, err_code       sticky error; 1 illegal, 2 mem_system err, 3 watchdog
//   hit_cnt, miss_cnt        completions in the accept cycle / after stall cycles
//   Addr, DataIn, Rd, Wr     request toward mem_system
//   DataOut, Done, Stall, err  response from mem_system (Stall is informational)
module mem_req_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             pipe_stall,
    output logic             resp_valid,
    output logic [15:0]      resp_rdata,
    output logic             ctrl_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [15:0]      Addr,
    output logic [15:0]      DataIn,
    output logic             Rd,
    output logic             Wr,
    input  logic [15:0]      DataOut,
    input  logic             Done,
    input  logic             Stall,
    input  logic             err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t         state, state_nxt;
    logic [15:0]    addr_q, wdata_q, rdata_q;
    logic           rd_q, wr_q;
    logic [TW-1:0]  tmo_q;
    logic [1:0]     code_nxt;
    logic           legal, latch, hit_evt, miss_evt, tmo_clr, tmo_inc, code_set;
    logic           stall_unused;

    assign stall_unused = Stall;
    assign legal        = req_valid & (req_rd ^ req_wr) & ~req_addr[0];
    assign ctrl_err     = (state == ERR);

    always_comb begin
        state_nxt  = state;
        Addr       = '0;
        DataIn     = '0;
        Rd         = 1'b0;
        Wr         = 1'b0;
        pipe_stall = 1'b0;
        resp_valid = 1'b0;
        latch      = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        code_set   = 1'b0;
        code_nxt   = 2'd0;
        // Combinational outputs are forced low while reset is asserted.
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (legal) begin
                        Addr   = req_addr;
                        DataIn = req_wdata;
                        Rd     = req_rd;
                        Wr     = req_wr;
                        latch  = 1'b1;
                        if (Done) begin
                            resp_valid = 1'b1;
                            hit_evt    = 1'b1;
                        end else begin
                            pipe_stall = 1'b1;
                            tmo_clr    = 1'b1;
                            state_nxt  = BUSY;
                        end
                    end else if (req_valid) begin
                        pipe_stall = 1'b1;
                        code_set   = 1'b1;
                        code_nxt   = 2'd1;
                        state_nxt  = ERR;
                    end
                end
                BUSY: begin
                    Addr   = addr_q;
                    DataIn = wdata_q;
                    Rd     = rd_q;
                    Wr     = wr_q;
                    if (Done) begin
                        resp_valid = 1'b1;
                        miss_evt   = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        pipe_stall = 1'b1;
                        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            code_set  = 1'b1;
                            code_nxt  = 2'd3;
                            state_nxt = ERR;
                        end else begin
                            tmo_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    pipe_stall = 1'b1;
                end
            endcase
            // mem_system error wins over Done and any other transition.
            if (err && state != ERR) begin
                resp_valid = 1'b0;
                hit_evt    = 1'b0;
                miss_evt   = 1'b0;
                pipe_stall = 1'b1;
                code_set   = 1'b1;
                code_nxt   = 2'd2;
                state_nxt  = ERR;
            end
        end
        resp_rdata = resp_valid ? (Rd ? DataOut : '0) : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            tmo_q    <= '0;
            rdata_q  <= '0;
            err_code <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                wr_q    <= req_wr;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (resp_valid) begin
                rdata_q <= resp_rdata;
            end
            if (code_set) begin
                err_code <= code_nxt;
            end
            if (hit_evt && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (miss_evt && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

    localparam int unsigned CW   = 4;
    localparam int unsigned TMO  = 64;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_rd, req_wr;
    logic [15:0]   req_addr, req_wdata;
    logic          pipe_stall, resp_valid, ctrl_err;
    logic [15:0]   resp_rdata, Addr, DataIn, DataOut;
    logic [1:0]    err_code;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic          Rd, Wr, Done, Stall, err;

    int n_chk = 0;
    int n_err = 0;

    mem_req_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .pipe_stall(pipe_stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ctrl_err(ctrl_err), .err_code(err_code),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding request, how long it has waited,
    // whether the controller has died and why, and the counts/last data.
    logic        m_busy = 0, m_err = 0, m_rd = 0, m_wr = 0;
    logic [1:0]  m_code = 0;
    logic [15:0] m_addr = 0, m_din = 0, m_rdata = 0;
    int          m_wait = 0, m_hit = 0, m_miss = 0;

    logic        e_rd, e_wr, e_stall, e_rv, lg;
    logic [15:0] e_addr, e_din, e_rdata;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_err = 0; m_code = 0; m_wait = 0;
            m_hit = 0; m_miss = 0; m_rdata = 0;
            chk("rst_ctl", 32'({pipe_stall, resp_valid, ctrl_err, err_code, Rd, Wr, hit_cnt, miss_cnt}), 32'd0);
            chk("rst_data", {resp_rdata, Addr}, 32'd0);
            chk("rst_din", 32'(DataIn), 32'd0);
        end else begin
            chk("m_ctrl_err", 32'(ctrl_err), 32'(m_err));
            chk("m_err_code", 32'(err_code), 32'(m_code));
            chk("m_hit_cnt", 32'(hit_cnt), 32'(m_hit));
            chk("m_miss_cnt", 32'(miss_cnt), 32'(m_miss));
            e_rd = 0; e_wr = 0; e_addr = 0; e_din = 0;
            e_stall = 0; e_rv = 0; e_rdata = m_rdata;
            lg = req_valid && (req_rd != req_wr) && !req_addr[0];
            if (m_err) begin
                e_stall = 1;
                chk("m_err_rdwr", 32'({Rd, Wr}), 32'd0);
            end else begin
                if (m_busy) begin
                    e_rd = m_rd; e_wr = m_wr; e_addr = m_addr; e_din = m_din;
                end else if (lg) begin
                    e_rd = req_rd; e_wr = req_wr; e_addr = req_addr; e_din = req_wdata;
                end
                if (err) begin
                    e_stall = 1; m_err = 1; m_code = 2;
                end else if (!m_busy && req_valid && !lg) begin
                    e_stall = 1; m_err = 1; m_code = 1;
                end else if ((e_rd || e_wr) && Done) begin
                    e_rv = 1;
                    e_rdata = e_rd ? DataOut : 16'h0;
                    m_rdata = e_rdata;
                    if (m_busy) m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
                    else        m_hit  = (m_hit  < CMAX) ? m_hit  + 1 : CMAX;
                    m_busy = 0;
                end else if (e_rd || e_wr) begin
                    e_stall = 1;
                    if (!m_busy) begin
                        m_busy = 1; m_wait = 0;
                        m_rd = e_rd; m_wr = e_wr; m_addr = e_addr; m_din = e_din;
                    end else if (m_wait == TMO - 1) begin
                        m_err = 1; m_code = 3;
                    end else begin
                        m_wait++;
                    end
                end
                chk("m_bus", {e_addr, 14'd0, e_rd, e_wr}, {Addr, 14'd0, Rd, Wr});
                chk("m_din", 32'(DataIn), 32'(e_din));
            end
            chk("m_stall_rv", 32'({pipe_stall, resp_valid}), 32'({e_stall, e_rv}));
            chk("m_rdata", 32'(resp_rdata), 32'(e_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0; req_rd = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        Done = 0; err = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic load(input logic [15:0] a, input logic d, input logic [15:0] dout);
        req_valid = 1; req_rd = 1; req_wr = 0; req_addr = a; req_wdata = 16'h0;
        Done = d; DataOut = dout;
    endtask

    int stalls, bad, n, err_age;

    initial begin
        rst = 0; Stall = 0; DataOut = 0;
        idle();
        #2;
        chk("reset_stall", 32'(pipe_stall), 32'd0);
        chk("reset_bus", 32'({Rd, Wr, Addr}), 32'd0);
        tick(); tick();
        rst = 1;

        // Hit: load with same-cycle Done
        load(16'h0010, 1, 16'hBEEF);
        #2;
        chk("hit_rv", 32'(resp_valid), 32'd1);
        chk("hit_rdata", 32'(resp_rdata), 32'h0000BEEF);
        chk("hit_stall", 32'(pipe_stall), 32'd0);
        chk("hit_rd_addr", 32'({Rd, Addr}), 32'h00010010);
        tick(); idle(); DataOut = 16'h7777;
        #2;
        chk("hit_cnt1", 32'(hit_cnt), 32'd1);
        chk("rdata_hold", 32'(resp_rdata), 32'h0000BEEF);
        tick();

        // Miss: store, Done on the 9th cycle, req_* randomized meanwhile
        req_valid = 1; req_rd = 0; req_wr = 1; req_addr = 16'h0200; req_wdata = 16'h1234;
        stalls = 0; bad = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                req_valid = 1'($urandom); req_rd = 1'($urandom); req_wr = 1'($urandom);
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end
            Done = (i == 8); DataOut = 16'($urandom);
            #2;
            if (pipe_stall) stalls++;
            if (Addr != 16'h0200 || DataIn != 16'h1234 || !Wr || Rd) bad++;
            if (i == 8) begin
                chk("miss_rv", 32'(resp_valid), 32'd1);
                chk("miss_rdata", 32'(resp_rdata), 32'd0);
            end
            tick();
        end
        idle();
        chk("miss_stalls", 32'(stalls), 32'd8);
        chk("miss_stable", 32'(bad), 32'd0);
        #2;
        chk("miss_cnt1", 32'(miss_cnt), 32'd1);
        tick();

        // Odd address: rejected, sticky until reset
        load(16'h0003, 1, 16'h1111);
        #2;
        chk("odd_rd", 32'(Rd), 32'd0);
        chk("odd_rv", 32'(resp_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            load(16'h0004, 1, 16'h2222);
            #2;
            chk("odd_sticky", 32'({ctrl_err, err_code, pipe_stall, Rd, resp_valid}), 32'b1_01_1_0_0);
            tick();
        end

        // Watchdog: Done withheld
        do_reset();
        load(16'h0040, 0, 16'h0);
        tick(); idle();
        n = 0;
        while (!ctrl_err && n < 100) begin
            tick();
            n++;
        end
        chk("wdog_cycles", 32'(n), 32'd64);
        chk("wdog_code", 32'(err_code), 32'd3);

        // err and Done together in BUSY
        do_reset();
        load(16'h0042, 0, 16'h0);
        tick(); idle();
        tick();
        err = 1; Done = 1; DataOut = 16'h3333;
        #2;
        chk("err_no_rv", 32'(resp_valid), 32'd0);
        tick(); idle();
        #2;
        chk("err_code2", 32'({ctrl_err, err_code}), 32'b1_10);
        tick();

        // Async reset mid-BUSY, then a normal request
        do_reset();
        load(16'h0080, 0, 16'h0);
        tick(); idle();
        tick();
        #2 rst = 0;
        #1;
        chk("arst_outs", 32'({pipe_stall, resp_valid, ctrl_err, Rd, Wr, Addr}), 32'd0);
        tick();
        rst = 1;
        load(16'h0082, 1, 16'h5A5A);
        #2;
        chk("arst_next_rv", 32'(resp_valid), 32'd1);
        chk("arst_next_rdata", 32'(resp_rdata), 32'h00005A5A);
        tick(); idle();
        #2;
        chk("arst_hit", 32'(hit_cnt), 32'd1);

        // Saturation of hit_cnt
        for (int i = 0; i < 20; i++) begin
            load(16'(2 * i), 1, 16'(i));
            tick();
        end
        idle();
        #2;
        chk("hit_sat", 32'(hit_cnt), 32'(CMAX));
        tick();

        // Randomized traffic against the model
        err_age = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_err) err_age++;
            if (err_age > 3) begin
                rst = 0;
                err_age = 0;
            end else begin
                rst = 1;
            end
            req_valid = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 15);
            req_rd = (n == 0) ? 1'b1 : n[0];
            req_wr = (n == 0) ? 1'b1 : ~n[0];
            req_addr = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 15) == 0) req_addr[0] = 1'b1;
            req_wdata = 16'($urandom);
            DataOut = 16'($urandom);
            Done = ($urandom_range(0, 2) == 0);
            err = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1;
        idle();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
